// File: rtl/luma_exposure_sched.sv
// luma_exposure_sched: shares one Y_comp luma engine between the short (ch0)
// and long (ch1) HDR exposure streams. Each RGB stream is buffered in a small
// FIFO. Pixels are issued to the engine one per cycle. The engine's returned
// luma is routed back to the owning channel by a tag pipe that runs alongside
// the engine.
// Optional macro FRAME_LOCK_EN: frame-atomic arbitration. A channel keeps the
// engine until it issues a pixel with frame_end set.
module luma_exposure_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int LUMA_LAT   = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] ch0_R,
    input  logic [7:0] ch0_G,
    input  logic [7:0] ch0_B,
    input  logic       ch0_valid,
    input  logic       ch0_frame_end,
    output logic       ch0_ready,
    input  logic [7:0] ch1_R,
    input  logic [7:0] ch1_G,
    input  logic [7:0] ch1_B,
    input  logic       ch1_valid,
    input  logic       ch1_frame_end,
    output logic       ch1_ready,
    output logic [7:0] lum_R,
    output logic [7:0] lum_G,
    output logic [7:0] lum_B,
    output logic       lum_valid,
    output logic       lum_frame_end,
    input  logic [7:0] lum_Y,
    input  logic       lum_valid_ret,
    input  logic       lum_fe_ret,
    output logic [7:0] y0,
    output logic       y0_valid,
    output logic       y0_frame_end,
    output logic [7:0] y1,
    output logic       y1_valid,
    output logic       y1_frame_end,
    output logic       err_sync
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(LUMA_LAT + 1);

    logic [1:0][24:0] in_word;
    logic [1:0]       in_vld;
    logic [1:0][24:0] head_w;
    logic [1:0]       nempty;
    logic [1:0]       rdy;
    logic [1:0]       pop;
    logic             gnt_vld;
    logic             gnt_ch;
    logic [24:0]      head;

    assign in_word[0] = {ch0_R, ch0_G, ch0_B, ch0_frame_end};
    assign in_word[1] = {ch1_R, ch1_G, ch1_B, ch1_frame_end};
    assign in_vld     = {ch1_valid, ch0_valid};
    assign ch0_ready  = rdy[0];
    assign ch1_ready  = rdy[1];

    // Per-channel input FIFO. Ready is registered from the next-state count.
    for (genvar c = 0; c < 2; c++) begin : g_fifo
        logic [24:0]   mem_q [FIFO_DEPTH];
        logic [AW-1:0] wp_q, rp_q;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          rdy_q;
        logic          push;

        assign push      = in_vld[c] & rdy_q;
        assign cnt_d     = cnt_q + CW'(push) - CW'(pop[c]);
        assign nempty[c] = (cnt_q != '0);
        assign head_w[c] = mem_q[rp_q];
        assign rdy[c]    = rdy_q;

        // Pointer, count and ready update; storage is not reset.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                wp_q  <= '0;
                rp_q  <= '0;
                cnt_q <= '0;
                rdy_q <= 1'b0;
            end else begin
                if (push) begin
                    mem_q[wp_q] <= in_word[c];
                    wp_q        <= wp_q + 1'b1;
                end
                if (pop[c]) rp_q <= rp_q + 1'b1;
                cnt_q <= cnt_d;
                rdy_q <= (cnt_d < CW'(FIFO_DEPTH));
            end
        end
    end

    // prio_q holds the channel that wins a tie, which is the channel not granted last.
    logic prio_q;

`ifdef FRAME_LOCK_EN
    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} lock_e;
    lock_e st_q;
`endif

    // Grant selection. Under frame lock, a locked channel is served exclusively.
    always_comb begin
        gnt_vld = |nempty;
        gnt_ch  = nempty[1] & (~nempty[0] | prio_q);
`ifdef FRAME_LOCK_EN
        case (st_q)
            LOCK0: begin gnt_vld = nempty[0]; gnt_ch = 1'b0; end
            LOCK1: begin gnt_vld = nempty[1]; gnt_ch = 1'b1; end
            default: ;
        endcase
`endif
    end

    assign pop  = {gnt_vld & gnt_ch, gnt_vld & ~gnt_ch};
    assign head = head_w[gnt_ch];

    logic [7:0] lum_R_q, lum_G_q, lum_B_q;
    logic       lum_valid_q, lum_fe_q, lum_ch_q;

    // Issue register, round-robin pointer and lock FSM.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lum_R_q     <= '0;
            lum_G_q     <= '0;
            lum_B_q     <= '0;
            lum_valid_q <= 1'b0;
            lum_fe_q    <= 1'b0;
            lum_ch_q    <= 1'b0;
            prio_q      <= 1'b0;
`ifdef FRAME_LOCK_EN
            st_q        <= IDLE;
`endif
        end else begin
            lum_valid_q <= gnt_vld;
            if (gnt_vld) begin
                {lum_R_q, lum_G_q, lum_B_q, lum_fe_q} <= head;
                lum_ch_q <= gnt_ch;
                prio_q   <= ~gnt_ch;
`ifdef FRAME_LOCK_EN
                if (head[0])     st_q <= IDLE;
                else if (gnt_ch) st_q <= LOCK1;
                else             st_q <= LOCK0;
`endif
            end
        end
    end

    assign lum_R         = lum_R_q;
    assign lum_G         = lum_G_q;
    assign lum_B         = lum_B_q;
    assign lum_valid     = lum_valid_q;
    assign lum_frame_end = lum_fe_q;

    // The tag pipe is fed from the issue register, so its head lines up with lum_valid_ret.
    logic [LUMA_LAT-1:0] tv_q, tc_q;
    logic [HW-1:0]       hold_q;
    logic                head_v, head_c, hold_done, ret_ok, ret_bad;

    assign head_v    = tv_q[LUMA_LAT-1];
    assign head_c    = tc_q[LUMA_LAT-1];
    assign hold_done = (hold_q == '0);
    assign ret_ok    = hold_done & head_v & lum_valid_ret;
    assign ret_bad   = hold_done & (head_v ^ lum_valid_ret);

    logic [7:0] y0_q, y1_q;
    logic       y0_v_q, y1_v_q, y0_fe_q, y1_fe_q, err_q;

    // Tag shift, post-reset holdoff, return routing and the sticky error flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tv_q    <= '0;
            tc_q    <= '0;
            hold_q  <= HW'(LUMA_LAT);
            y0_q    <= '0;
            y1_q    <= '0;
            y0_v_q  <= 1'b0;
            y1_v_q  <= 1'b0;
            y0_fe_q <= 1'b0;
            y1_fe_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            tv_q[0] <= lum_valid_q;
            tc_q[0] <= lum_ch_q;
            for (int i = 1; i < LUMA_LAT; i++) begin
                tv_q[i] <= tv_q[i-1];
                tc_q[i] <= tc_q[i-1];
            end
            if (!hold_done) hold_q <= hold_q - 1'b1;
            y0_v_q  <= ret_ok & ~head_c;
            y1_v_q  <= ret_ok &  head_c;
            y0_fe_q <= ret_ok & ~head_c & lum_fe_ret;
            y1_fe_q <= ret_ok &  head_c & lum_fe_ret;
            if (ret_ok & ~head_c) y0_q <= lum_Y;
            if (ret_ok &  head_c) y1_q <= lum_Y;
            err_q   <= err_q | ret_bad;
        end
    end

    assign y0           = y0_q;
    assign y0_valid     = y0_v_q;
    assign y0_frame_end = y0_fe_q;
    assign y1           = y1_q;
    assign y1_valid     = y1_v_q;
    assign y1_frame_end = y1_fe_q;
    assign err_sync     = err_q;

endmodule
